cpu_control_unit: RTL

Fetch/execute sequencer for the 4-bit CPU. It fetches 8-bit instructions over a req/ack handshake and drives the 2-entry register file's write and read controls. It computes results with an internal 4-bit ALU and emits values on a valid/ready output port. It is the only master of the register file's write port.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_alu.sv | 42 ++++
 rtl/cpu_control_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU control unit:
// opcodes, FSM state encoding, instruction field positions.
package cpu_pkg;

   localparam int DATA_W = 4;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LDI  = 3'd1;
   localparam logic [2:0] OP_MOV  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_OUT  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 5;
   localparam int RD_BIT = 4;
   localparam int ARG_HI = 3;
   localparam int ARG_LO = 0;
   localparam int RS_BIT = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_OUTW,
      S_HALT
   } state_t;

   function automatic logic writes_rf(input logic [2:0] op);
      return op inside {OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND};
   endfunction

   function automatic logic sets_flags(input logic [2:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND};
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 4-bit ALU.
// Ports: a, b operands; op opcode; result, carry, zero.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b};

   // LDI and MOV pass b through; the top selects b accordingly.
   always_comb begin
      result = b;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = w_sum[DATA_W-1:0];
            carry  = w_sum[DATA_W];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: begin
            result = a & b;
         end
         default: begin
            result = b;
         end
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/execute sequencer of the 4-bit CPU.
// Ports: clk, reset (async, low); run; instruction fetch
// req/ack; register file write/read controls; out valid/ready
// port; flag_c, flag_z, halted status.
module cpu_control_unit #(
   parameter int                DATA_W   = 4,
   parameter int                ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              instr_req,
   input  logic              instr_ack,
   input  logic [7:0]        instr_data,
   output logic              rf_we,
   output logic              rf_write_sel,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_read_sel,
   input  logic [DATA_W-1:0] rf_read_data,
   input  logic [DATA_W-1:0] rf_R0,
   input  logic [DATA_W-1:0] rf_R1,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              flag_c,
   output logic              flag_z,
   output logic              halted
);

   import cpu_pkg::*;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_c;
   logic              r_z;
   logic              r_halt;

   logic [2:0]        w_op;
   logic              w_rd;
   logic [DATA_W-1:0] w_arg;
   logic [DATA_W-1:0] w_rd_val;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_res;
   logic              w_c;
   logic              w_z;

   assign w_op  = r_ir[OPC_HI:OPC_LO];
   assign w_rd  = r_ir[RD_BIT];
   assign w_arg = r_ir[ARG_HI:ARG_LO];

   // R[rd] comes from the direct taps; R[rs] through the
   // read port, whose select is the registered IR bit.
   assign w_rd_val = w_rd ? rf_R1 : rf_R0;
   assign w_b      = (w_op == OP_LDI) ? w_arg : rf_read_data;

   cpu_alu u_alu (
      .a      (w_rd_val),
      .b      (w_b),
      .op     (w_op),
      .result (w_res),
      .carry  (w_c),
      .zero   (w_z)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (run) w_next = S_FETCH;
         S_FETCH: if (instr_ack) w_next = S_EXEC;
         S_EXEC: begin
            if (w_op == OP_OUT)       w_next = S_OUTW;
            else if (w_op == OP_HALT) w_next = S_HALT;
            else                      w_next = S_FETCH;
         end
         S_OUTW:  if (out_ready) w_next = S_FETCH;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      instr_req     = (r_state == S_FETCH);
      rf_we         = 1'b0;
      rf_write_sel  = 1'b0;
      rf_write_data = '0;
      if (r_state == S_EXEC && writes_rf(w_op)) begin
         rf_we         = 1'b1;
         rf_write_sel  = w_rd;
         rf_write_data = w_res;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_halt      <= 1'b0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (instr_ack) r_ir <= instr_data;
            end
            S_EXEC: begin
               if (w_op == OP_OUT) begin
                  r_out_data  <= w_rd_val;
                  r_out_valid <= 1'b1;
               end else if (w_op == OP_HALT) begin
                  r_halt <= 1'b1;
               end else begin
                  r_pc <= r_pc + ADDR_W'(1);
               end
               if (sets_flags(w_op)) begin
                  r_c <= w_c;
                  r_z <= w_z;
               end
            end
            S_OUTW: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= r_pc + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign instr_addr  = r_pc;
   assign rf_read_sel = r_ir[RS_BIT];
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign flag_c      = r_c;
   assign flag_z      = r_z;
   assign halted      = r_halt;

endmodule
